// File: rtl/uart_pkg.sv
// Shared types and constants for the UART debug line transmitter.
package uart_pkg;

    // Parity mode encoding; the numeric values match the PARITY parameter.
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_t;

    // Transmitter FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic [7:0] UART_LF = 8'h0A;

    // Parity bit for one byte: even parity is the XOR of the data bits,
    // odd parity is its inverse.
    function automatic logic parity_bit(input logic [7:0] b, input parity_t mode);
        return (mode == PAR_ODD) ? ~(^b) : (^b);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud counter: counts 0..CLK_DIV-1 and strobes o_tick on the last cycle
// of each bit. i_clr holds the counter at 0 so the first bit after a
// restart is exactly CLK_DIV cycles wide.
module uart_baud_tick #(
    parameter int CLK_DIV = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running bit-period counter, cleared by reset or i_clr.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // The counter is 0 whenever it is cleared, and CLK_DIV >= 2, so the
    // strobe cannot fire while cleared.
    assign o_tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART line transmitter: accepts NUM_CHARS bytes in one handshake and sends
// them MSB-character first, each byte LSB first, with optional parity,
// 1 or 2 stop bits and an optional trailing line feed.
//
// Handshake: a transfer is accepted on a rising clk edge where
// i_valid && o_ready. o_ready is high only while idle; i_valid while busy
// is ignored and not remembered. i_data is only sampled at the accept.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 434,
    parameter int NUM_CHARS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int APPEND_LF = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [NUM_CHARS-1:0][7:0] i_data,
    output logic                      o_tx,
    output logic                      o_busy,
    output logic                      o_fin,
    output tx_state_t                 o_state
);

    // Elaboration-time parameter checks.
    if (CLK_DIV < 2) begin : g_chk_div
        $error("uart_tx_frame: CLK_DIV must be >= 2");
    end
    if (NUM_CHARS < 1 || NUM_CHARS > 32) begin : g_chk_chars
        $error("uart_tx_frame: NUM_CHARS must be 1..32");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_par
        $error("uart_tx_frame: PARITY must be 0..2");
    end

    localparam int IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);
    localparam parity_t PAR_MODE = parity_t'(PARITY[1:0]);

    tx_state_t                 state;
    logic                      tx_q;
    logic                      ready_q;
    logic                      fin_q;
    logic [NUM_CHARS-1:0][7:0] data_q;
    logic [IDX_W-1:0]          idx;
    logic                      lf_pending;  // LF still owed after the characters
    logic                      lf_active;   // character on the line is the LF
    logic [6:0]                shreg;       // remaining data bits of current byte
    logic [2:0]                bit_cnt;
    logic                      par_q;
    logic                      stop_cnt;
    logic                      tick;
    logic [7:0]                next_byte;

    // Baud timer is held at 0 while idle, so it restarts on every accept.
    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (state == ST_IDLE),
        .o_tick (tick)
    );

    // Byte to serialise once the current start bit ends.
    always_comb begin
        next_byte = lf_active ? UART_LF : data_q[idx];
    end

    // Transmit FSM with registered line, ready and completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            fin_q      <= 1'b0;
            data_q     <= '0;
            idx        <= '0;
            lf_pending <= 1'b0;
            lf_active  <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            par_q      <= 1'b0;
            stop_cnt   <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_valid && ready_q) begin
                        data_q     <= i_data;
                        idx        <= LAST_IDX;
                        lf_pending <= (APPEND_LF != 0);
                        lf_active  <= 1'b0;
                        tx_q       <= 1'b0;
                        ready_q    <= 1'b0;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx_q    <= next_byte[0];
                        shreg   <= next_byte[7:1];
                        par_q   <= parity_bit(next_byte, PAR_MODE);
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt == 3'd7) begin
                            if (PAR_MODE != PAR_NONE) begin
                                tx_q  <= par_q;
                                state <= ST_PARITY;
                            end else begin
                                tx_q     <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= ST_STOP;
                            end
                        end else begin
                            tx_q    <= shreg[0];
                            shreg   <= {1'b0, shreg[6:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        tx_q     <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (STOP_BITS == 2 && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else if (idx != '0) begin
                            idx   <= idx - 1'b1;
                            tx_q  <= 1'b0;
                            state <= ST_START;
                        end else if (lf_pending) begin
                            lf_pending <= 1'b0;
                            lf_active  <= 1'b1;
                            tx_q       <= 1'b0;
                            state      <= ST_START;
                        end else begin
                            lf_active <= 1'b0;
                            ready_q   <= 1'b1;
                            fin_q     <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_tx    = tx_q;
    assign o_ready = ready_q;
    assign o_busy  = !ready_q;
    assign o_fin   = fin_q;
    assign o_state = state;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four instances cover the basic frame, even and
// odd parity, and two stop bits without LF. Expected line bits come from a
// small frame model pushed to a queue when each transfer is driven.
module tb_uart_tx_frame;
    import uart_pkg::*;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] valid = 4'b0000;
    logic [1:0][7:0] data_a = '0;
    logic [0:0][7:0] data_e = '0;
    logic [0:0][7:0] data_o = '0;
    logic [0:0][7:0] data_s = '0;
    wire  [3:0] tx, ready, busy, fin;
    tx_state_t st0, st1, st2, st3;

    // Per-instance frame settings: chars, parity, stop bits, LF.
    int nc_t   [4] = '{2, 1, 1, 1};
    int par_t  [4] = '{0, 2, 1, 0};
    int stop_t [4] = '{1, 1, 1, 2};
    int lf_t   [4] = '{1, 0, 0, 0};

    int n_cmp = 0;
    int n_err = 0;
    int fin_cnt [4] = '{default: 0};
    logic [0:0] exp_q[$];

    // Clock
    always #5 clk = ~clk;

    uart_tx_frame #(.CLK_DIV(DIV), .NUM_CHARS(2), .PARITY(0), .STOP_BITS(1), .APPEND_LF(1)) dut_a (
        .clk(clk), .rst(rst), .i_valid(valid[0]), .o_ready(ready[0]), .i_data(data_a),
        .o_tx(tx[0]), .o_busy(busy[0]), .o_fin(fin[0]), .o_state(st0));
    uart_tx_frame #(.CLK_DIV(DIV), .NUM_CHARS(1), .PARITY(2), .STOP_BITS(1), .APPEND_LF(0)) dut_e (
        .clk(clk), .rst(rst), .i_valid(valid[1]), .o_ready(ready[1]), .i_data(data_e),
        .o_tx(tx[1]), .o_busy(busy[1]), .o_fin(fin[1]), .o_state(st1));
    uart_tx_frame #(.CLK_DIV(DIV), .NUM_CHARS(1), .PARITY(1), .STOP_BITS(1), .APPEND_LF(0)) dut_o (
        .clk(clk), .rst(rst), .i_valid(valid[2]), .o_ready(ready[2]), .i_data(data_o),
        .o_tx(tx[2]), .o_busy(busy[2]), .o_fin(fin[2]), .o_state(st2));
    uart_tx_frame #(.CLK_DIV(DIV), .NUM_CHARS(1), .PARITY(0), .STOP_BITS(2), .APPEND_LF(0)) dut_s (
        .clk(clk), .rst(rst), .i_valid(valid[3]), .o_ready(ready[3]), .i_data(data_s),
        .o_tx(tx[3]), .o_busy(busy[3]), .o_fin(fin[3]), .o_state(st3));

    // Count completion pulses on each instance.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (fin[k] === 1'b1) fin_cnt[k]++;
        end
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input logic v, input logic [15:0] d);
        valid[k] = v;
        case (k)
            0: data_a = d;
            1: data_e = d[7:0];
            2: data_o = d[7:0];
            default: data_s = d[7:0];
        endcase
    endtask

    // Frame model: start, 8 data bits LSB first, optional parity, stop bits.
    task automatic push_char(input int k, input logic [7:0] b);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        if (par_t[k] == 2) exp_q.push_back(^b);
        if (par_t[k] == 1) exp_q.push_back(~(^b));
        for (int i = 0; i < stop_t[k]; i++) exp_q.push_back(1'b1);
    endtask

    task automatic push_frame(input int k, input logic [15:0] d);
        for (int c = nc_t[k] - 1; c >= 0; c--) push_char(k, d[c*8 +: 8]);
        if (lf_t[k] != 0) push_char(k, 8'h0A);
    endtask

    // Drive one transfer and check every cycle of the line against the
    // queue. Returns #1 into the cycle where o_fin must be high.
    task automatic do_frame(input int k, input logic [15:0] d, input bit hold, input bit meddle);
        int nbits;
        int w;
        logic [0:0] eb;
        drive(k, 1'b1, d);
        exp_q.delete();
        push_frame(k, d);
        nbits = exp_q.size();
        w = 0;
        while (ready[k] !== 1'b1 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        chk($sformatf("accept_wait_k%0d", k), 32'(w < 200), 32'd1);
        @(posedge clk); #1;
        if (!hold) valid[k] = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            eb = exp_q.pop_front();
            for (int c = 0; c < DIV; c++) begin
                chk($sformatf("tx_k%0d_b%0d_c%0d", k, b, c), 32'(tx[k]), 32'(eb));
                if (c == 0) begin
                    chk($sformatf("ready_k%0d_b%0d", k, b), 32'(ready[k]), 32'd0);
                    chk($sformatf("busy_k%0d_b%0d", k, b), 32'(busy[k]), 32'd1);
                    chk($sformatf("fin_k%0d_b%0d", k, b), 32'(fin[k]), 32'd0);
                    if (meddle && b == 5) drive(k, 1'b1, 16'hFFFF);
                    if (meddle && b == 6) valid[k] = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        chk($sformatf("fin_pulse_k%0d", k), 32'(fin[k]), 32'd1);
        chk($sformatf("fin_ready_k%0d", k), 32'(ready[k]), 32'd1);
        chk($sformatf("fin_tx_idle_k%0d", k), 32'(tx[k]), 32'd1);
    endtask

    task automatic step_fin_low(input int k);
        @(posedge clk); #1;
        chk($sformatf("fin_one_cycle_k%0d", k), 32'(fin[k]), 32'd0);
    endtask

    initial begin
        int base;
        // Reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_tx_k%0d", k), 32'(tx[k]), 32'd1);
            chk($sformatf("rst_ready_k%0d", k), 32'(ready[k]), 32'd1);
            chk($sformatf("rst_busy_k%0d", k), 32'(busy[k]), 32'd0);
            chk($sformatf("rst_fin_k%0d", k), 32'(fin[k]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic frame "AB" + LF: 30 bits x 4 cycles, o_fin at T+121
        do_frame(0, 16'h4142, 1'b0, 1'b0);
        step_fin_low(0);

        // Parity: byte 07, even -> parity 1, odd -> parity 0
        do_frame(1, 16'h0007, 1'b0, 1'b0);
        step_fin_low(1);
        do_frame(2, 16'h0007, 1'b0, 1'b0);
        step_fin_low(2);

        // Two stop bits, no LF, byte 55: o_fin at T+45
        do_frame(3, 16'h0055, 1'b0, 1'b0);
        step_fin_low(3);

        // Back-to-back with i_valid held high
        do_frame(0, 16'h3132, 1'b1, 1'b0);
        do_frame(0, 16'h3334, 1'b0, 1'b0);
        step_fin_low(0);

        // Requests and data changes while busy are ignored
        do_frame(0, 16'h4344, 1'b0, 1'b1);
        step_fin_low(0);
        data_a = '0;

        // Reset mid-bit, during a 0 data bit
        base = fin_cnt[0];
        drive(0, 1'b1, 16'h5A5A);
        @(posedge clk); #1;
        valid[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_tx_low", 32'(tx[0]), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_tx", 32'(tx[0]), 32'd1);
        chk("midrst_ready", 32'(ready[0]), 32'd1);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_fin", 32'(fin[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst_tx", 32'(tx[0]), 32'd1);
        chk("postrst_ready", 32'(ready[0]), 32'd1);
        repeat (150) @(posedge clk);
        #1;
        chk("no_fin_after_abort", 32'(fin_cnt[0]), 32'(base));
        chk("idle_tx_after_abort", 32'(tx[0]), 32'd1);

        // Completion pulse totals
        chk("fin_total_a", 32'(fin_cnt[0]), 32'd4);
        chk("fin_total_e", 32'(fin_cnt[1]), 32'd1);
        chk("fin_total_o", 32'(fin_cnt[2]), 32'd1);
        chk("fin_total_s", 32'(fin_cnt[3]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
